// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer for an 8-channel serial ADC with a pipelined address.
// Drives cs_n/sclk/mosi and returns each result tagged with the channel it belongs to.
//
// state    | meaning
// ST_IDLE  | cs_n high, waiting for en and a non-empty chan_mask
// ST_SHIFT | cs_n low, 2*FRAME sclk half-periods, then the store half-period
// ST_GAP   | cs_n high for GAP cycles; the store cycle is the first of them
module adc_scan_ctrl #(
  parameter int CLKDIV = 4,
  parameter int GAP    = 2,
  parameter int NCHAN  = 8,
  parameter int CHAN_W = 3,
  parameter int DATLEN = 12,
  parameter int FRAME  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCHAN-1:0]  chan_mask,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic [DATLEN-1:0] sample,
  output logic [CHAN_W-1:0] sample_chan,
  output logic              sample_vld,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int HALF_N  = 2 * FRAME + 1;
  localparam int PH_W    = $clog2(HALF_N + 1);
  localparam int TMR_MAX = (CLKDIV > GAP) ? CLKDIV : GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKDIV - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP - 1);

  logic [1:0]        state;
  logic [TMR_W-1:0]  tmr;
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   ph_nxt;
  logic [FRAME-1:0]  tx_sr;
  logic [FRAME-1:0]  tx_word;
  logic [DATLEN-1:0] rx_sr;
  logic [CHAN_W-1:0] addr_cur;
  logic [CHAN_W-1:0] addr_prev;
  logic [CHAN_W-1:0] base;
  logic [CHAN_W-1:0] idx;
  logic [CHAN_W-1:0] next_addr;
  logic              prime;
  logic              start;
  logic              launch;
  logic              tmr_tc;

  // Search upward from the last address; from IDLE the base is the top channel so the lowest bit wins.
  always_comb begin
    base      = (state == ST_IDLE) ? CHAN_W'(NCHAN - 1) : addr_cur;
    next_addr = base;
    idx       = '0;
    for (int i = NCHAN; i >= 1; i--) begin
      idx = base + CHAN_W'(i);
      if (chan_mask[idx]) next_addr = idx;
    end
  end

  assign tx_word = FRAME'(next_addr) << (FRAME - 2 - CHAN_W);
  assign start   = en && (chan_mask != '0);
  assign tmr_tc  = (tmr == '0);
  assign launch  = start && ((state == ST_IDLE) || ((state == ST_GAP) && tmr_tc));
  assign ph_nxt  = ph + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      ph          <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      addr_cur    <= '0;
      addr_prev   <= '0;
      prime       <= 1'b1;
      cs_n        <= 1'b1;
      sclk        <= 1'b1;
      mosi        <= 1'b0;
      sample      <= '0;
      sample_chan <= '0;
      sample_vld  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sample_vld <= 1'b0;
      if (launch) begin
        state     <= ST_SHIFT;
        cs_n      <= 1'b0;
        busy      <= 1'b1;
        tmr       <= HALF_LOAD;
        ph        <= '0;
        tx_sr     <= tx_word;
        mosi      <= tx_word[FRAME-1];
        addr_prev <= addr_cur;
        addr_cur  <= next_addr;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (tmr_tc) begin
              tmr <= HALF_LOAD;
              ph  <= ph_nxt;
              if (ph_nxt == PH_W'(HALF_N)) begin
                // Store: this frame carries the conversion addressed in the previous frame.
                cs_n  <= 1'b1;
                state <= ST_GAP;
                tmr   <= GAP_LOAD;
                if (prime) begin
                  prime <= 1'b0;
                end else begin
                  sample      <= rx_sr;
                  sample_chan <= addr_prev;
                  sample_vld  <= 1'b1;
                end
              end else if (ph_nxt[0]) begin
                sclk <= 1'b0;
                mosi <= tx_sr[FRAME-1];
              end else begin
                sclk  <= 1'b1;
                rx_sr <= {rx_sr[DATLEN-2:0], miso};
                tx_sr <= {tx_sr[FRAME-2:0], 1'b0};
              end
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          ST_GAP: begin
            if (tmr_tc) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              prime <= 1'b1;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          ST_IDLE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Sequencer for the 8-channel serial ADC (ADC128S022-style: 16-clock frames, 3-bit channel address on DIN, 4 leading zeros then 12 data bits on DOUT). Generates `cs_n`, `sclk` and `mosi`, and scans the channels enabled in `chan_mask` in round-robin order. It de-serialises each result and presents it, tagged with its channel, as a one-cycle valid pulse to the acquisition logic. The ADC pipelines the address, so each frame returns the conversion for the address sent in the previous frame.

## Interface
- `CLKDIV`, 4: `clk` cycles per `sclk` half-period; minimum 1.
- `GAP`, 2: `clk` cycles `cs_n` stays high between frames; minimum 1.
- `NCHAN`, 8: number of ADC channels.
- `CHAN_W`, 3: channel index width; log2(`NCHAN`).
- `DATLEN`, 12: result width.
- `FRAME`, 16: `sclk` pulses per frame.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  scan enable.
- `chan_mask`  in  `NCHAN`  bit i = scan channel i.
- `miso`  in  1  ADC DOUT.
- `cs_n`  out  1  ADC chip select, active low.
- `sclk`  out  1  ADC serial clock, idle high.
- `mosi`  out  1  ADC DIN.
- `sample`  out  `DATLEN`  last result, held until the next result.
- `sample_chan`  out  `CHAN_W`  channel of `sample`.
- `sample_vld`  out  1  one-cycle pulse when `sample` and `sample_chan` update.
- `busy`  out  1  high from `cs_n` fall until the end of the following gap.

## Operation
- Reset values: `cs_n`=1, `sclk`=1, `mosi`=0, `sample`=0, `sample_chan`=0, `sample_vld`=0, `busy`=0. FSM enters IDLE and sets the prime flag.
- **IDLE:** go to SHIFT (pull `cs_n` low) when `en`=1 and `chan_mask`≠0. Otherwise stay in IDLE with `cs_n` high.
- **Channel selection at frame start:**
  - Address = next set bit of `chan_mask` strictly above the previously addressed channel, ascending, wrapping past `NCHAN`-1 to 0.
  - The first frame after IDLE starts the search from channel `NCHAN`-1, so it picks the lowest set bit.
  - `chan_mask` is sampled only at frame start.
- **SHIFT:**
  - 16 `sclk` pulses. `mosi` is MSB-first: bits 0–1 = 0, bits 2–4 = address[2:0], bits 5–15 = 0.
  - Bit k is driven at falling edge k of `sclk`; bit 0 is driven at the `cs_n` fall.
  - `miso` is captured at rising edge k. Bits 0–3 are discarded; bits 4–15 form the result, MSB first.
- **STORE** (the single cycle in which `cs_n` rises):
  - If the prime flag is clear: load `sample`, load `sample_chan` from the address register of the previous frame, and pulse `sample_vld`.
  - If the prime flag is set: clear it; no pulse.
- **GAP:** hold `cs_n` high for `GAP` cycles. Then start a new frame if `en`=1 and `chan_mask`≠0; otherwise go to IDLE and set the prime flag.
- `en` deasserted mid-frame: the current frame completes and its result is delivered (unless it is the prime frame); then IDLE.
- `chan_mask` changes mid-scan: the tag always reflects the address actually sent, so results stay correct.
- Async reset mid-frame: outputs take their reset values immediately. The first frame after reset is a prime frame.

## Timing
- Frame start t0 = the `cs_n` falling cycle.
- `sclk` edge k (k = 0..15):
  - falls at t0 + `CLKDIV` + 2·`CLKDIV`·k;
  - rises at t0 + 2·`CLKDIV`·(k+1).
- `cs_n` rises, and `sample_vld` pulses, at t0 + 2·`CLKDIV`·`FRAME` + `CLKDIV`. Defaults: t0+132.
- The next `cs_n` fall comes `GAP` cycles later. Frame period = (2·`FRAME`+1)·`CLKDIV` + `GAP` = 134 cycles by default.
- First valid result after enable: two frame periods minus `GAP` after the first `cs_n` fall.
- `sclk` and `mosi` change only while `cs_n`=0. `sclk`=1 whenever `cs_n`=1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SHIFT -> `cs_n`=1, `sclk`=1, `mosi`=0, `sample`=0, `sample_vld`=0, `busy`=0 immediately. After release with `en`=1, the first frame produces no `sample_vld`.
- **Scan:** `chan_mask`=8'b0000_0101, `en`=1; ADC model returns 12'hA00 | channel.
  - Frame addresses sent: 0, 2, 0, 2.
  - Frame 1: no pulse.
  - Frame 2: `sample_vld` with `sample_chan`=0, `sample`=12'hA00.
  - Frame 3: `sample_chan`=2, `sample`=12'hA02.
- **Timing** (defaults): `cs_n` low for 132 cycles, period 134, exactly 16 `sclk` pulses of 8 cycles each, `mosi` stable across every rising edge.
- **Masks:** `chan_mask`=0 with `en`=1 -> `cs_n` stays 1 and `busy`=0. `chan_mask`=8'h80 -> every frame addresses 7, and results are tagged 7 from frame 2 onward.
- **Disable:** drop `en` at t0+40 of frame 3 -> frame 3 completes with one `sample_vld`, then IDLE. Re-enable -> the next frame is a prime frame (no pulse).
- **Mask change:** change `chan_mask` from 8'h03 to 8'h0C mid-frame -> the in-flight result is still tagged with the old channel; the next address is 2.
